mem_stream_reader: RTL and testbench



---
 rtl/mem_stream_pkg.sv | 16 +
 rtl/stream_fifo2.sv | 60 ++++++
 rtl/mem_stream_reader.sv | 105 ++++++++++
 tb/tb_mem_stream_reader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stream_pkg.sv
// Shared types and constants for the memory burst stream reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } state_t;

  // Output buffer depth: one slot covers the RAM read latency, one covers a stalled consumer.
  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry register FIFO; the head entry drives the stream data directly.
// Latency: a pushed word is visible at head in the cycle after the push edge.
// Backpressure: none internally; the caller must never push when full or pop when empty.
module stream_fifo2
  import mem_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] e0;
  logic [WIDTH-1:0] e1;

  assign head = e0;

  // Shift-style storage: e0 is always the oldest word, e1 the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0  <= '0;
      e1  <= '0;
      occ <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) e0 <= din;
          else             e1 <= din;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new word lands behind whatever stays.
          if (occ == 2'd1) begin
            e0 <= din;
          end else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  // The issue throttle upstream guarantees these never fire.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && occ == 2'(BUF_DEPTH)));
  assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && occ == 2'd0));

endmodule

// File: rtl/mem_stream_reader.sv
// Burst reader: issues len sequential RAM reads from base_addr (wrapping) and streams the words out.
// Latency: first m_valid 3 cycles after start; done N+3 cycles after start when never stalled.
// Backpressure: m_ready low holds the head word; reads stop while buffer plus in-flight read fill 2 slots.
module mem_stream_reader
  import mem_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW:0]      len,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_en,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_do,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] addr;
  logic [AW:0]   remaining;
  logic [AW:0]   issued;
  logic          inflight;
  logic [1:0]    occ;
  logic          pop;
  logic          issue;
  logic          final_issue;

  assign pop     = m_valid && m_ready;
  assign m_valid = (occ != 2'd0);
  assign mem_we  = 1'b0;
  assign mem_en  = issue;
  assign mem_addr = issue ? addr : '0;
  assign busy    = (state == RUN) || (state == DRAIN);
  assign done    = (state == FIN);

  // Issue only if the word it returns is guaranteed a buffer slot, counting this cycle's pop.
  always_comb begin
    issue = 1'b0;
    if (state == RUN) begin
      issue = ({1'b0, occ} + {2'b00, inflight}) < (3'(BUF_DEPTH) + {2'b00, pop});
    end
    final_issue = issue && ((issued + (AW+1)'(1)) == remaining);
  end

  // Next-state logic; DRAIN exits as the last buffered word leaves so done lands the cycle after.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (len != '0) ? RUN : FIN;
      RUN:   if (final_issue) state_nxt = DRAIN;
      DRAIN: if (!inflight && (occ == 2'd0 || (occ == 2'd1 && pop))) state_nxt = FIN;
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Burst bookkeeping: latch the command, advance the read address, track the outstanding read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
      issued    <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue;
      if (state == IDLE && start) begin
        addr      <= base_addr;
        remaining <= len;
        issued    <= '0;
      end else if (issue) begin
        addr   <= (addr == AW'(DEPTH - 1)) ? '0 : addr + AW'(1);
        issued <= issued + (AW+1)'(1);
      end
    end
  end

  stream_fifo2 #(
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .din   (mem_do),
    .pop   (pop),
    .occ   (occ),
    .head  (m_data)
  );

endmodule

// File: tb/tb_mem_stream_reader.sv
// Self-checking bench for mem_stream_reader with a RAM model, scoreboard queue and stream monitor.
// Latency: checks start-to-valid and start-to-done timing on an unstalled burst.
// Backpressure: drives m_ready constant, patterned, random or held low.
module tb_mem_stream_reader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [AW-1:0]    base_addr = '0;
  logic [AW:0]      len = '0;
  logic             busy;
  logic             done;
  logic [AW-1:0]    mem_addr;
  logic             mem_en;
  logic             mem_we;
  logic [WIDTH-1:0] mem_do = '0;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready = 1'b0;

  mem_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we),
    .mem_do(mem_do), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with one-cycle registered read.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) if (mem_en) mem_do <= mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q [$];

  int start_cyc = 0;
  int first_valid = -1;
  int done_rel = -1;
  int en_cnt = 0;
  int done_cnt = 0;
  int rd_total = 0;
  int pop_total = 0;
  bit track_busy = 0;
  bit prev_stall = 0;
  logic [WIDTH-1:0] prev_data = '0;
  int rmode = 0;
  int pat [8] = '{1, 0, 0, 1, 0, 1, 1, 1};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // m_ready driver: 0 always high, 1 fixed pattern, 2 random, 3 held low.
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: m_ready = 1'b1;
      1: m_ready = pat[cyc % 8][0];
      2: m_ready = ($urandom_range(0, 3) != 0);
      default: m_ready = 1'b0;
    endcase
  end

  // Monitor: scoreboard pops, stall stability, occupancy bound, busy/done behaviour.
  always @(negedge clk) begin
    int rel;
    int items;
    if (!rst_n) begin
      prev_stall = 0;
      rd_total = 0;
      pop_total = 0;
    end else begin
      rel = cyc - start_cyc;
      items = rd_total + int'(mem_en) - pop_total - int'(m_valid && m_ready);
      checks++;
      if (items > 2 || items < 0) begin
        errors++;
        $display("FAIL occupancy: got %0d expected 0..2", items);
      end
      if (mem_en) begin
        rd_total++;
        en_cnt++;
      end
      if (prev_stall) begin
        checks++;
        if (!m_valid || m_data != prev_data) begin
          errors++;
          $display("FAIL stall_hold: got valid=%0b data=%0d expected valid=1 data=%0d",
                   m_valid, m_data, prev_data);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      if (m_valid && first_valid < 0) first_valid = rel;
      if (m_valid && m_ready) begin
        pop_total++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra: got word %0d expected none", m_data);
        end else begin
          logic [WIDTH-1:0] e;
          e = exp_q.pop_front();
          if (m_data != e) begin
            errors++;
            $display("FAIL stream_data: got %0d expected %0d", m_data, e);
          end
        end
      end
      if (track_busy && rel >= 1) begin
        checks++;
        if (busy != !done) begin
          errors++;
          $display("FAIL busy: got %0b expected %0b", busy, !done);
        end
      end
      if (done) begin
        done_cnt++;
        done_rel = rel;
        checks++;
        if (!track_busy) begin
          errors++;
          $display("FAIL done_unexpected: got done=1 expected 0");
        end
        track_busy = 0;
      end
    end
  end

  task automatic start_burst(input int b, input int l);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = AW'(b);
    len = (AW+1)'(l);
    start_cyc = cyc;
    first_valid = -1;
    done_rel = -1;
    en_cnt = 0;
    track_busy = 1;
    for (int i = 0; i < l; i++) exp_q.push_back(mem[(b + i) % DEPTH]);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic finish_burst(input string name, input int l, input int d0, input int maxcyc);
    int n;
    n = 0;
    while (done_cnt == d0 && n < maxcyc) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_done_seen"}, int'(done_cnt != d0), 1);
    chk({name, "_queue_left"}, exp_q.size(), 0);
    chk({name, "_reads"}, en_cnt, l);
    exp_q.delete();
  endtask

  task automatic run_burst(input string name, input int b, input int l);
    int d0;
    d0 = done_cnt;
    start_burst(b, l);
    finish_burst(name, l, d0, 2000);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int d0;
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_data", int'(m_data), 0);
    chk("rst_mem_en", int'(mem_en), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst_n = 1'b1;

    // Unstalled burst: timing of first valid and done.
    rmode = 0;
    run_burst("basic", 5, 4);
    chk("basic_first_valid", first_valid, 3);
    chk("basic_done_cycle", done_rel, 7);

    // Wrap-around.
    run_burst("wrap", 62, 4);
    chk("wrap_done_cycle", done_rel, 7);

    // Fixed backpressure pattern.
    rmode = 1;
    run_burst("bp", 20, 6);
    rmode = 0;

    // Zero-length command.
    run_burst("len0", 9, 0);
    chk("len0_done_cycle", done_rel, 1);
    chk("len0_no_valid", first_valid, -1);

    // Reset while two words sit in the buffer.
    rmode = 3;
    start_burst(30, 16);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_reads", en_cnt, 2);
    chk("abort_valid_pre", int'(m_valid), 1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort_m_valid", int'(m_valid), 0);
    chk("abort_m_data", int'(m_data), 0);
    chk("abort_mem_en", int'(mem_en), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    exp_q.delete();
    track_busy = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    chk("abort_no_done", done_cnt, d0);
    rmode = 0;
    run_burst("post_abort", 0, 2);

    // Start re-pulsed while busy is ignored.
    d0 = done_cnt;
    start_burst(10, 5);
    #1;
    start = 1'b1;
    base_addr = AW'(40);
    len = (AW+1)'(9);
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_burst("repulse", 5, d0, 200);
    repeat (6) @(posedge clk);
    chk("repulse_single_done", done_cnt - d0, 1);

    // Full-depth burst under random stalls.
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom);
    rmode = 2;
    run_burst("full", 17, DEPTH);

    // Random bursts.
    for (int k = 0; k < 25; k++) begin
      run_burst("rand", int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH)));
    end
    rmode = 0;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
